// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_subtractor_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_ctrl_full_subtractor_bit.sv
// One-bit full subtractor made of two half subtractors and an OR on the
// borrows; both outputs are forced low when disabled.
module full_subtractor_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    input  logic en,
    output logic d,
    output logic bout
);

    logic hs1_d;
    logic hs1_b;
    logic hs2_d;
    logic hs2_b;

    always_comb begin
        hs1_d = x ^ y;
        hs1_b = ~x & y;
        hs2_d = hs1_d ^ bin;
        hs2_b = ~hs1_d & bin;
        d     = en & hs2_d;
        bout  = en & (hs1_b | hs2_b);
    end

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: runs one full-subtractor cell LSB-first for
// WIDTH cycles and publishes a - b plus the final borrow with a done pulse.
module serial_subtractor_ctrl
    import serial_subtractor_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic             brw_q, brw_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             cell_en;
    logic             cell_d;
    logic             cell_bout;
    logic [WIDTH-1:0] res_shifted;

    assign cell_en = (state_q == ST_RUN);

    full_subtractor_bit u_cell (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bin  (brw_q),
        .en   (cell_en),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // New bit enters at the MSB; after WIDTH shifts bit 0 is the LSB of a - b.
    assign res_shifted = {cell_d, res_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        brw_d   = brw_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_RUN;
                    a_sr_d  = a;
                    b_sr_d  = b;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    a_sr_d = a_sr_q >> 1;
                    b_sr_d = b_sr_q >> 1;
                    brw_d  = cell_bout;
                    res_d  = res_shifted[WIDTH-1:1];
                    if (cnt_q == LAST_BIT) begin
                        state_d = ST_DONE;
                        diff_d  = res_shifted;
                        bout_d  = cell_bout;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Status outputs are registered copies of the next state.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            brw_q   <= 1'b0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            brw_q   <= brw_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl: directed cases plus
// randomized back-to-back and abort traffic against a behavioural model.
module tb_serial_subtractor_ctrl;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an op is a countdown of W cycles, then a - b appears.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_diff = '0;
    logic         m_borrow = 1'b0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    int           m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_diff = '0; m_borrow = 1'b0; m_left = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_busy) begin
            if (abort) begin
                m_busy = 1'b0;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy   = 1'b0;
                    m_done   = 1'b1;
                    m_diff   = W'(int'(m_a) - int'(m_b));
                    m_borrow = (m_a < m_b);
                end
            end
        end else if (start && !abort) begin
            m_a = a; m_b = b; m_busy = 1'b1; m_left = W;
        end
    end

    int cyc = 0;
    int done_cnt = 0;
    int busy_cycles = 0;
    int last_done = -1;
    bit spacing_on = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            check("cycle_outputs", {21'd0, busy, done, borrow_out, diff},
                  {21'd0, m_busy, m_done, m_borrow, m_diff});
            if (busy) busy_cycles++;
            if (done) begin
                done_cnt++;
                if (spacing_on && last_done >= 0) check("done_spacing", cyc - last_done, W + 2);
                last_done = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input string name);
        int  base = done_cnt;
        bit  ok = 1'b0;
        for (int i = 0; i < 3 * W + 10; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt > base) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input string name);
        tick();
        a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(name);
    endtask

    initial begin
        int base;
        bit ok;

        #3;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_diff", 32'(diff), 32'd0);
        check("reset_borrow", 32'(borrow_out), 32'd0);
        #10 rst_n = 1'b1;

        // Basic op with busy-length measurement
        tick();
        a = 8'h05; b = 8'h03; start = 1'b1; busy_cycles = 0;
        tick();
        start = 1'b0;
        wait_done("t1_done");
        check("t1_busy_cycles", 32'(busy_cycles), 32'd8);
        check("t1_diff", 32'(diff), 32'h02);
        check("t1_borrow", 32'(borrow_out), 32'd0);

        run_op(8'h00, 8'h01, "t2a_done");
        check("t2a_diff", 32'(diff), 32'hFF);
        check("t2a_borrow", 32'(borrow_out), 32'd1);
        run_op(8'hA5, 8'hA5, "t2b_done");
        check("t2b_diff", 32'(diff), 32'h00);
        check("t2b_borrow", 32'(borrow_out), 32'd0);

        // abort wins over start in IDLE
        tick();
        tick();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_beats_start", 32'(busy), 32'd0);

        // start re-pulsed during RUN is ignored
        base = done_cnt;
        tick();
        a = 8'h10; b = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        a = 8'h77; b = 8'h99; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t3_done");
        repeat (W + 4) tick();
        check("t3_one_done", 32'(done_cnt - base), 32'd1);
        check("t3_diff", 32'(diff), 32'h0F);
        check("t3_borrow", 32'(borrow_out), 32'd0);

        // abort in the fourth RUN cycle
        base = done_cnt;
        tick();
        a = 8'h40; b = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_busy_after_abort", 32'(busy), 32'd0);
        repeat (W + 4) tick();
        check("t4_no_done", 32'(done_cnt - base), 32'd0);
        check("t4_diff_kept", 32'(diff), 32'h0F);
        run_op(8'h20, 8'h30, "t4_restart_done");
        check("t4_restart_diff", 32'(diff), 32'hF0);
        check("t4_restart_borrow", 32'(borrow_out), 32'd1);

        // async reset between edges mid-RUN
        base = done_cnt;
        tick();
        a = 8'h33; b = 8'h11; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #1 rst_n = 1'b0;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_diff", 32'(diff), 32'd0);
        check("t5_borrow", 32'(borrow_out), 32'd0);
        #2 rst_n = 1'b1;
        repeat (W + 4) tick();
        check("t5_no_done", 32'(done_cnt - base), 32'd0);

        // start held high: back-to-back random ops
        tick();
        last_done = -1;
        spacing_on = 1'b1;
        base = done_cnt;
        start = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 1000 * (W + 2) + 50; i++) begin
            a = W'($urandom); b = W'($urandom);
            tick();
            if (done_cnt - base >= 1000) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        repeat (W + 4) tick();
        spacing_on = 1'b0;
        check("t6_ops_completed", 32'(ok), 32'd1);

        // random start/abort traffic
        for (int i = 0; i < 2000; i++) begin
            start = ($urandom % 4) != 0;
            abort = ($urandom % 16) == 0;
            a = W'($urandom); b = W'($urandom);
            tick();
        end
        start = 1'b0; abort = 1'b0;
        repeat (W + 4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
